wb_sim_uart_fifo: RTL and testbench

- Simulation-only NS16550-flavoured UART on Wishbone. Successor to the single-byte dummy serial port.
- TX: parametrised FIFO drained on a valid/ready byte stream with programmable inter-byte gap.
- RX: testbench-injected byte stream into a parametrised FIFO, read through RHR.
- Real LSR/ISR status and a level interrupt; sits on the SoC peripheral bus in sim builds in place of the hardware UART.

---
 rtl/wb_sim_uart_fifo_if.sv | 30 +++
 rtl/wb_sim_uart_fifo.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_wb_sim_uart_fifo.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sim_uart_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_sim_uart_fifo_if
//  Brief    : Wishbone classic slave bus bundle for the simulation UART.
//  Revision : 1.0 - initial release
// ============================================================================
interface wb_sim_uart_fifo_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic [AW-1:0]   wb_adr_i;
    logic [DW-1:0]   wb_dat_i;
    logic [DW-1:0]   wb_dat_o;
    logic            wb_we_i;
    logic [DW/8-1:0] wb_sel_i;
    logic            wb_ack_o;
    logic            wb_cyc_i;
    logic            wb_stb_i;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_sim_uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_sim_uart_fifo
//  Brief    : Simulation-only NS16550-style UART on Wishbone with TX/RX FIFOs,
//             valid/ready byte streams, LSR/ISR status and a level interrupt.
//             Optional: define WB_SIM_UART_LOOPBACK_EN for MCR[4] loopback.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_sim_uart_fifo #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int TX_GAP   = 0
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_reset_ni,
    wb_sim_uart_fifo_if.slave    wb,
    output logic [7:0]           uart_tx_data,
    output logic                 uart_tx_valid,
    input  logic                 uart_tx_ready,
    input  logic [7:0]           uart_rx_data,
    input  logic                 uart_rx_valid,
    output logic                 uart_rx_ready,
    output logic                 irq_o
);

    localparam int c_TXA   = $clog2(TX_DEPTH);
    localparam int c_RXA   = $clog2(RX_DEPTH);
    localparam int c_GAP_W = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;

    localparam logic [7:0] c_ADR_THR = 8'h00;
    localparam logic [7:0] c_ADR_IER = 8'h01;
    localparam logic [7:0] c_ADR_ISR = 8'h02;
    localparam logic [7:0] c_ADR_LCR = 8'h03;
    localparam logic [7:0] c_ADR_MCR = 8'h04;
    localparam logic [7:0] c_ADR_LSR = 8'h05;
    localparam logic [7:0] c_ADR_MSR = 8'h06;
    localparam logic [7:0] c_ADR_SCR = 8'h07;

    localparam logic [c_TXA:0]   c_TX_ONE  = (c_TXA + 1)'(1);
    localparam logic [c_RXA:0]   c_RX_ONE  = (c_RXA + 1)'(1);
    localparam logic [c_GAP_W-1:0] c_GAP_LD = c_GAP_W'(TX_GAP);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE = c_GAP_W'(1);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       r_ack;
    logic [7:0] r_dat;
    logic       w_stb_valid;
    logic       w_acc;
    logic       w_wr;
    logic       w_rd;
    logic [7:0] w_adr;
    logic [7:0] w_wdat;
    logic       w_unused;

    assign w_stb_valid = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
    assign w_acc       = w_stb_valid & wb.wb_sel_i[0];
    assign w_wr        = w_acc & wb.wb_we_i;
    assign w_rd        = w_acc & ~wb.wb_we_i;
    assign w_adr       = wb.wb_adr_i[7:0];
    assign w_wdat      = wb.wb_dat_i[7:0];
    assign w_unused    = ^{wb.wb_adr_i, wb.wb_dat_i, wb.wb_sel_i};

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    logic [1:0] r_ier;
    logic [7:0] r_lcr;
    logic [7:0] r_mcr;
    logic [7:0] r_scr;
    logic       r_oe;
    logic       r_irq;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [7:0]       r_tx_mem [TX_DEPTH];
    logic [c_TXA:0]   r_tx_wp;
    logic [c_TXA:0]   r_tx_rp;
    logic [c_TXA:0]   w_tx_rp_nxt;
    logic             w_tx_empty;
    logic             w_tx_full;
    logic [7:0]       w_tx_head;
    logic             w_tx_avail;
    logic             w_tx_push;
    logic             w_tx_pop;
    logic             w_tx_flush;
    logic [c_GAP_W-1:0] r_gap;

    logic [7:0]       r_rx_mem [RX_DEPTH];
    logic [c_RXA:0]   r_rx_wp;
    logic [c_RXA:0]   r_rx_rp;
    logic             w_rx_empty;
    logic             w_rx_full;
    logic [7:0]       w_rx_head;
    logic             w_rx_push;
    logic             w_rx_do_push;
    logic [7:0]       w_rx_wdata;
    logic             w_rx_pop;
    logic             w_rx_flush;
    logic             w_rx_ovf;

    logic             w_lsr_rd;
    logic             w_dr;
    logic             w_thre;
    logic             w_temt;
    logic [7:0]       w_lsr;
    logic [7:0]       w_isr;
    logic [7:0]       w_rd_byte;

    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp[c_TXA] != r_tx_rp[c_TXA]) &&
                        (r_tx_wp[c_TXA-1:0] == r_tx_rp[c_TXA-1:0]);
    assign w_tx_head  = r_tx_mem[r_tx_rp[c_TXA-1:0]];
    assign w_tx_avail = ~w_tx_empty & (r_gap == '0);

    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[c_RXA] != r_rx_rp[c_RXA]) &&
                        (r_rx_wp[c_RXA-1:0] == r_rx_rp[c_RXA-1:0]);
    assign w_rx_head  = r_rx_mem[r_rx_rp[c_RXA-1:0]];

    assign w_tx_push  = w_wr && (w_adr == c_ADR_THR) && !w_tx_full;
    assign w_tx_flush = w_wr && (w_adr == c_ADR_ISR) && w_wdat[2];
    assign w_rx_flush = w_wr && (w_adr == c_ADR_ISR) && w_wdat[1];
    assign w_rx_pop   = w_rd && (w_adr == c_ADR_THR) && !w_rx_empty;
    assign w_lsr_rd   = w_rd && (w_adr == c_ADR_LSR);

    // ------------------------------------------------------------------
    // Stream path selection
    // ------------------------------------------------------------------
`ifdef WB_SIM_UART_LOOPBACK_EN
    logic w_lb;
    logic w_lb_push;

    assign w_lb          = r_mcr[4];
    // Loopback still honours the gap counter via w_tx_avail.
    assign w_lb_push     = w_lb & w_tx_avail & ~w_rx_full & ~w_rx_flush;
    assign uart_tx_valid = w_tx_avail & ~w_lb;
    assign uart_rx_ready = ~w_rx_full & ~w_lb;
    assign w_tx_pop      = w_lb ? w_lb_push : (w_tx_avail & uart_tx_ready);
    assign w_rx_push     = w_lb ? w_lb_push
                                : (uart_rx_valid & (~w_rx_full | w_rx_pop));
    assign w_rx_wdata    = w_lb ? w_tx_head : uart_rx_data;
    assign w_rx_ovf      = ~w_lb & uart_rx_valid & w_rx_full & ~w_rx_pop;
`else
    assign uart_tx_valid = w_tx_avail;
    assign uart_rx_ready = ~w_rx_full;
    assign w_tx_pop      = w_tx_avail & uart_tx_ready;
    // A pop on the same cycle frees the slot, so a full FIFO still accepts.
    assign w_rx_push     = uart_rx_valid & (~w_rx_full | w_rx_pop);
    assign w_rx_wdata    = uart_rx_data;
    assign w_rx_ovf      = uart_rx_valid & w_rx_full & ~w_rx_pop;
`endif

    assign uart_tx_data  = w_tx_head;
    assign w_rx_do_push  = w_rx_push & ~w_rx_flush;
    assign w_tx_rp_nxt   = w_tx_pop ? (r_tx_rp + c_TX_ONE) : r_tx_rp;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wp[c_TXA-1:0]] <= w_wdat;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
        end else begin
            r_tx_rp <= w_tx_rp_nxt;
            if (w_tx_flush) begin
                // A head already on the stream must survive until accepted.
                r_tx_wp <= (uart_tx_valid & ~w_tx_pop) ? (r_tx_rp + c_TX_ONE)
                                                        : w_tx_rp_nxt;
            end else if (w_tx_push) begin
                r_tx_wp <= r_tx_wp + c_TX_ONE;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            r_gap <= '0;
        end else if (w_tx_pop) begin
            r_gap <= c_GAP_LD;
        end else if (r_gap != '0) begin
            r_gap <= r_gap - c_GAP_ONE;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (w_rx_do_push) begin
            r_rx_mem[r_rx_wp[c_RXA-1:0]] <= w_rx_wdata;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else if (w_rx_flush) begin
            r_rx_rp <= r_rx_wp;
        end else begin
            if (w_rx_pop) begin
                r_rx_rp <= r_rx_rp + c_RX_ONE;
            end
            if (w_rx_do_push) begin
                r_rx_wp <= r_rx_wp + c_RX_ONE;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            r_oe <= 1'b0;
        end else if (w_rx_ovf) begin
            r_oe <= 1'b1;
        end else if (w_lsr_rd) begin
            r_oe <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register writes
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            r_ier <= '0;
            r_lcr <= '0;
            r_mcr <= '0;
            r_scr <= '0;
        end else if (w_wr) begin
            case (w_adr)
                c_ADR_IER: r_ier <= w_wdat[1:0];
                c_ADR_LCR: r_lcr <= w_wdat;
                c_ADR_MCR: r_mcr <= w_wdat;
                c_ADR_SCR: r_scr <= w_wdat;
                default:   ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status and read mux
    // ------------------------------------------------------------------
    assign w_dr   = ~w_rx_empty;
    assign w_thre = w_tx_empty;
    assign w_temt = w_thre & ~uart_tx_valid;
    assign w_lsr  = {1'b0, w_temt, w_thre, 3'b000, r_oe, w_dr};

    always_comb begin
        w_isr = 8'h01;
        if (r_ier[0] & w_dr) begin
            w_isr = 8'h04;
        end else if (r_ier[1] & w_thre) begin
            w_isr = 8'h02;
        end
    end

    always_comb begin
        w_rd_byte = 8'h00;
        case (w_adr)
            c_ADR_THR: w_rd_byte = w_rx_empty ? 8'h00 : w_rx_head;
            c_ADR_IER: w_rd_byte = {6'b000000, r_ier};
            c_ADR_ISR: w_rd_byte = w_isr;
            c_ADR_LCR: w_rd_byte = r_lcr;
            c_ADR_MCR: w_rd_byte = r_mcr;
            c_ADR_LSR: w_rd_byte = w_lsr;
            c_ADR_MSR: w_rd_byte = 8'hB0;
            c_ADR_SCR: w_rd_byte = r_scr;
            default:   w_rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            r_ack <= 1'b0;
            r_dat <= 8'h00;
            r_irq <= 1'b0;
        end else begin
            r_ack <= w_stb_valid;
            r_dat <= w_rd ? w_rd_byte : 8'h00;
            r_irq <= (r_ier[0] & w_dr) | (r_ier[1] & w_thre);
        end
    end

    assign wb.wb_ack_o = r_ack;
    assign irq_o       = r_irq;

    generate
        if (DW > 8) begin : g_dat_pad
            assign wb.wb_dat_o = {{(DW-8){1'b0}}, r_dat};
        end else begin : g_dat_narrow
            assign wb.wb_dat_o = r_dat;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wb_sim_uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_sim_uart_fifo
//  Brief    : Scoreboard bench for wb_sim_uart_fifo (TX order/gap/stall,
//             RX overflow, flushes, interrupt and optional loopback).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_sim_uart_fifo;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TXD = 4;
    localparam int RXD = 4;
    localparam int GAP = 2;

    localparam logic [7:0] A_THR = 8'h00;
    localparam logic [7:0] A_IER = 8'h01;
    localparam logic [7:0] A_ISR = 8'h02;
    localparam logic [7:0] A_MCR = 8'h04;
    localparam logic [7:0] A_LSR = 8'h05;
    localparam logic [7:0] A_MSR = 8'h06;
    localparam logic [7:0] A_SCR = 8'h07;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] uart_tx_data;
    logic       uart_tx_valid;
    logic       uart_tx_ready = 1'b0;
    logic [7:0] uart_rx_data = 8'h00;
    logic       uart_rx_valid = 1'b0;
    logic       uart_rx_ready;
    logic       irq_o;

    wb_sim_uart_fifo_if #(.AW(AW), .DW(DW)) bus ();

    wb_sim_uart_fifo #(
        .AW(AW), .DW(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .TX_GAP(GAP)
    ) dut (
        .wb_clk_i      (clk),
        .wb_reset_ni   (rst_n),
        .wb            (bus.slave),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int         tx_acc[$];
    bit         lb_mode = 1'b0;
    int         lb_valid_seen = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // TX stream scoreboard and stall stability, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("tx_hold_valid", {31'b0, uart_tx_valid}, 32'd1);
                check("tx_hold_data", {24'b0, uart_tx_data}, {24'b0, prev_data});
            end
            if (uart_tx_valid && uart_tx_ready) begin
                check("tx_expected", {31'b0, tx_q.size() != 0}, 32'd1);
                if (tx_q.size() != 0)
                    check("tx_data", {24'b0, uart_tx_data}, {24'b0, tx_q.pop_front()});
                tx_acc.push_back(cyc);
            end
            if (lb_mode && uart_tx_valid) lb_valid_seen++;
            prev_stall = uart_tx_valid & ~uart_tx_ready;
            prev_data  = uart_tx_data;
        end
    end

    task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [7:0] wd,
                           output logic [7:0] rd);
        int t;
        bus.wb_adr_i = {24'b0, adr};
        bus.wb_dat_i = {24'b0, wd};
        bus.wb_we_i  = we;
        bus.wb_sel_i = 4'hF;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!bus.wb_ack_o && t < 16);
        check("wb_ack", {31'b0, bus.wb_ack_o}, 32'd1);
        rd = bus.wb_dat_o[7:0];
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] adr, input logic [7:0] d);
        logic [7:0] dummy;
        wb_xfer(1'b1, adr, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] adr, input logic [7:0] exp);
        logic [7:0] d;
        wb_xfer(1'b0, adr, 8'h00, d);
        check(tag, {24'b0, d}, {24'b0, exp});
    endtask

    task automatic tx_write(input logic [7:0] d);
        if (tx_q.size() < TXD) tx_q.push_back(d);
        wr(A_THR, d);
    endtask

    task automatic inject(input logic [7:0] d);
        check("rx_ready", {31'b0, uart_rx_ready}, {31'b0, rx_q.size() < RXD});
        if (rx_q.size() < RXD) rx_q.push_back(d);
        uart_rx_data  = d;
        uart_rx_valid = 1'b1;
        @(posedge clk); #1;
        uart_rx_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = '0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;

        // Reset values
        wait_cyc(3);
        check("rst_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        check("rst_dat", bus.wb_dat_o, 32'd0);
        check("rst_tx_valid", {31'b0, uart_tx_valid}, 32'd0);
        check("rst_rx_ready", {31'b0, uart_rx_ready}, 32'd1);
        check("rst_irq", {31'b0, irq_o}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(1);
        rd_chk("lsr_reset", A_LSR, 8'h60);
        rd_chk("isr_reset", A_ISR, 8'h01);
        rd_chk("msr", A_MSR, 8'hB0);
        wr(A_SCR, 8'hA5);
        rd_chk("scr", A_SCR, 8'hA5);
        rd_chk("unmapped", 8'h09, 8'h00);
        check("irq_idle", {31'b0, irq_o}, 32'd0);

        // TX ordering and inter-byte gap
        uart_tx_ready = 1'b1;
        tx_acc.delete();
        tx_write(8'h41);
        tx_write(8'h42);
        tx_write(8'h43);
        wait_cyc(12);
        check("gap_count", tx_acc.size(), 32'd3);
        if (tx_acc.size() == 3) begin
            check("gap_1", tx_acc[1] - tx_acc[0], GAP + 1);
            check("gap_2", tx_acc[2] - tx_acc[1], GAP + 1);
        end
        rd_chk("lsr_tx_done", A_LSR, 8'h60);

        // TX stall with overfill
        uart_tx_ready = 1'b0;
        for (int i = 0; i < TXD + 1; i++) tx_write(8'h50 + 8'(i));
        wait_cyc(5);
        rd_chk("lsr_tx_full", A_LSR, 8'h00);
        tx_acc.delete();
        uart_tx_ready = 1'b1;
        wait_cyc(20);
        check("stall_count", tx_acc.size(), TXD);
        check("stall_drain", tx_q.size(), 32'd0);

        // TX flush keeps a presented head
        uart_tx_ready = 1'b0;
        tx_write(8'h61);
        tx_write(8'h62);
        tx_write(8'h63);
        wait_cyc(2);
        wr(A_ISR, 8'h04);
        while (tx_q.size() > 1) void'(tx_q.pop_back());
        rd_chk("lsr_flush_head", A_LSR, 8'h00);
        tx_acc.delete();
        uart_tx_ready = 1'b1;
        wait_cyc(8);
        check("flush_count", tx_acc.size(), 32'd1);
        rd_chk("lsr_flush_done", A_LSR, 8'h60);

        // RX overflow and OE clear-on-read
        for (int i = 0; i < RXD + 1; i++) inject(8'h30 + 8'(i));
        rd_chk("lsr_oe", A_LSR, 8'h63);
        rd_chk("lsr_oe_clr", A_LSR, 8'h61);

        // Same-cycle pop and push on a full RX FIFO
        wait_cyc(1);
        bus.wb_adr_i  = {24'b0, A_THR};
        bus.wb_we_i   = 1'b0;
        bus.wb_sel_i  = 4'hF;
        bus.wb_cyc_i  = 1'b1;
        bus.wb_stb_i  = 1'b1;
        uart_rx_data  = 8'hEE;
        uart_rx_valid = 1'b1;
        @(posedge clk); #1;
        uart_rx_valid = 1'b0;
        bus.wb_cyc_i  = 1'b0;
        bus.wb_stb_i  = 1'b0;
        check("pp_ack", {31'b0, bus.wb_ack_o}, 32'd1);
        check("pp_data", bus.wb_dat_o, {24'b0, rx_q.pop_front()});
        rx_q.push_back(8'hEE);
        check("pp_still_full", {31'b0, uart_rx_ready}, 32'd0);
        rd_chk("lsr_no_oe", A_LSR, 8'h61);
        for (int i = 0; i < RXD; i++) rd_chk("rhr_data", A_THR, rx_q.pop_front());
        rd_chk("rhr_empty", A_THR, 8'h00);
        rd_chk("lsr_rx_drained", A_LSR, 8'h60);

        // RX flush
        inject(8'h11);
        inject(8'h22);
        wr(A_ISR, 8'h02);
        rx_q.delete();
        rd_chk("lsr_rx_flush", A_LSR, 8'h60);
        rd_chk("rhr_after_flush", A_THR, 8'h00);

        // Interrupts
        wr(A_IER, 8'h01);
        wait_cyc(1);
        check("irq_no_data", {31'b0, irq_o}, 32'd0);
        inject(8'h5A);
        wait_cyc(1);
        check("irq_rx", {31'b0, irq_o}, 32'd1);
        rd_chk("isr_rx", A_ISR, 8'h04);
        rd_chk("rhr_irq", A_THR, rx_q.pop_front());
        check("irq_lag", {31'b0, irq_o}, 32'd1);
        wait_cyc(1);
        check("irq_clear", {31'b0, irq_o}, 32'd0);
        wr(A_IER, 8'h02);
        rd_chk("isr_thre", A_ISR, 8'h02);
        check("irq_thre", {31'b0, irq_o}, 32'd1);
        wr(A_IER, 8'h00);
        wait_cyc(2);
        check("irq_off", {31'b0, irq_o}, 32'd0);

`ifdef WB_SIM_UART_LOOPBACK_EN
        // Loopback
        lb_mode = 1'b1;
        lb_valid_seen = 0;
        wr(A_MCR, 8'h10);
        wr(A_THR, 8'h77);
        rx_q.push_back(8'h77);
        wait_cyc(4);
        check("lb_no_tx_valid", lb_valid_seen, 32'd0);
        check("lb_rx_ready", {31'b0, uart_rx_ready}, 32'd0);
        rd_chk("lb_lsr", A_LSR, 8'h61);
        rd_chk("lb_rhr", A_THR, rx_q.pop_front());
        wr(A_MCR, 8'h00);
        lb_mode = 1'b0;
`endif

        wait_cyc(4);
        check("tx_q_final", tx_q.size(), 32'd0);
        check("rx_q_final", rx_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
